// File: rtl/tag_ram_ctrl_pkg.sv
// Shared definitions for the tag RAM access controller: entry layout helpers,
// FSM state encoding and the arbiter grant-side encoding.
package tag_ram_ctrl_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef enum logic {
    SIDE_LK,
    SIDE_WR
  } side_t;

  // Entry layout: valid flag in the MSB, tag in the bits below it.
  function automatic int tag_width(input int dwidth);
    return dwidth - 1;
  endfunction

  function automatic int valid_bit(input int dwidth);
    return dwidth - 1;
  endfunction

endpackage

// File: rtl/tag_rr_arb2.sv
// Two-way round-robin arbiter (lookup vs write) with a last-grant register;
// ready/grant outputs are combinational, only the last-grant side is stored.
module tag_rr_arb2
  import tag_ram_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic req_lk,
  input  logic req_wr,
  output logic rdy_lk,
  output logic rdy_wr,
  output logic gnt_lk,
  output logic gnt_wr
);

  side_t last_q;

  // Under contention the side that did not win last time gets the slot.
  always_comb begin
    rdy_lk = enable && (!req_wr || (last_q == SIDE_WR));
    rdy_wr = enable && (!req_lk || (last_q == SIDE_LK));
    gnt_lk = rdy_lk && req_lk;
    gnt_wr = rdy_wr && req_wr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= SIDE_WR;
    end else if (gnt_lk) begin
      last_q <= SIDE_LK;
    end else if (gnt_wr) begin
      last_q <= SIDE_WR;
    end
  end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Access controller for one cache tag RAM bank: lookup/write arbitration, hit
// compare and statistics. Define TAG_RAM_CTRL_INIT_SWEEP_EN for a post-reset invalidate sweep.
module tag_ram_ctrl
  import tag_ram_ctrl_pkg::*;
#(
  parameter  int AWIDTH = 3,
  parameter  int DWIDTH = 7,
  parameter  int CNTW   = 16,
  localparam int TAGW   = tag_width(DWIDTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [AWIDTH-1:0] lk_index,
  input  logic [TAGW-1:0]   lk_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AWIDTH-1:0] rsp_index,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AWIDTH-1:0] wr_index,
  input  logic [TAGW-1:0]   wr_tag,
  input  logic              wr_inval,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [CNTW-1:0]   hit_cnt,
  output logic [CNTW-1:0]   miss_cnt
);

  localparam int VB = valid_bit(DWIDTH);

  state_t            state;
  logic              sweeping;
  logic [AWIDTH-1:0] sweep_addr;
  logic              run_en;
  logic              gnt_lk;
  logic              gnt_wr;
  logic [AWIDTH-1:0] addr_q;
  logic              pending_q;
  logic [AWIDTH-1:0] idx_q;
  logic [TAGW-1:0]   tag_q;

`ifdef TAG_RAM_CTRL_INIT_SWEEP_EN
  localparam int DEPTH = 1 << AWIDTH;

  logic [AWIDTH-1:0] sweep_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
    end else if (state == ST_INIT) begin
      sweep_ptr <= sweep_ptr + 1'b1;
      if (sweep_ptr == AWIDTH'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  assign sweeping   = (state == ST_INIT) && !reset;
  assign sweep_addr = sweep_ptr;
`else
  assign state      = ST_RUN;
  assign sweeping   = 1'b0;
  assign sweep_addr = '0;
`endif

  assign run_en = (state == ST_RUN) && !reset;

  tag_rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (run_en),
    .req_lk (lk_valid),
    .req_wr (wr_valid),
    .rdy_lk (lk_ready),
    .rdy_wr (wr_ready),
    .gnt_lk (gnt_lk),
    .gnt_wr (gnt_wr)
  );

  // The RAM port address holds its last value on idle cycles.
  always_comb begin
    ram_addr = addr_q;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (reset) begin
      ram_addr = '0;
    end else if (sweeping) begin
      ram_addr = sweep_addr;
      ram_we   = 1'b1;
    end else if (gnt_lk) begin
      ram_addr = lk_index;
    end else if (gnt_wr) begin
      ram_addr = wr_index;
      ram_we   = 1'b1;
      ram_din  = wr_inval ? '0 : {1'b1, wr_tag};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      tag_q     <= '0;
    end else begin
      addr_q    <= ram_addr;
      pending_q <= gnt_lk;
      if (gnt_lk) begin
        idx_q <= lk_index;
        tag_q <= lk_tag;
      end
    end
  end

  assign rsp_valid = pending_q;
  assign rsp_index = idx_q;
  assign rsp_hit   = pending_q && ram_dout[VB] && (ram_dout[TAGW-1:0] == tag_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (pending_q) begin
      if (rsp_hit) begin
        if (hit_cnt != {CNTW{1'b1}}) begin
          hit_cnt <= hit_cnt + 1'b1;
        end
      end else if (miss_cnt != {CNTW{1'b1}}) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Scoreboard bench for tag_ram_ctrl with a behavioural synchronous-read tag RAM;
// also checks the sweep when TAG_RAM_CTRL_INIT_SWEEP_EN is defined.
module tb_tag_ram_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 7;
  localparam int TW    = DW - 1;
  localparam int CW    = 3;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          hit;
  } rsp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          lk_valid;
  logic          lk_ready;
  logic [AW-1:0] lk_index;
  logic [TW-1:0] lk_tag;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [AW-1:0] rsp_index;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_index;
  logic [TW-1:0] wr_tag;
  logic          wr_inval;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout = '0;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  logic [DW-1:0] mem       [DEPTH] = '{default: '0};
  logic [DW-1:0] model_mem [DEPTH] = '{default: '0};
  rsp_t          exp_q[$];
  logic          mon_en  = 1'b0;
  logic          last_wr = 1'b1;
  int            exp_hit  = 0;
  int            exp_miss = 0;
  int            checks   = 0;
  int            errors   = 0;

  tag_ram_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .CNTW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .lk_valid  (lk_valid),
    .lk_ready  (lk_ready),
    .lk_index  (lk_index),
    .lk_tag    (lk_tag),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_index (rsp_index),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_index  (wr_index),
    .wr_tag    (wr_tag),
    .wr_inval  (wr_inval),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clock = ~clock;

  // Synchronous-read, read-first tag RAM.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [AW-1:0] li, input logic [TW-1:0] lt,
                               input logic wv, input logic [AW-1:0] wi, input logic [TW-1:0] wt,
                               input logic winv);
    lk_valid = lv;
    lk_index = li;
    lk_tag   = lt;
    wr_valid = wv;
    wr_index = wi;
    wr_tag   = wt;
    wr_inval = winv;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Scoreboard: responses from the previous cycle are retired before this cycle's grant is modelled.
  always @(negedge clock) begin
    if (mon_en) begin
      logic exp_lk;
      logic exp_wr;
      rsp_t e;
      checkOutput("rsp_valid", rsp_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rsp_valid) begin
          checkOutput("rsp_index", rsp_index, e.idx);
          checkOutput("rsp_hit", rsp_hit, e.hit);
          checkOutput("hit_cnt", hit_cnt, exp_hit);
          checkOutput("miss_cnt", miss_cnt, exp_miss);
          if (e.hit) exp_hit  = (exp_hit  == (1 << CW) - 1) ? exp_hit  : exp_hit + 1;
          else       exp_miss = (exp_miss == (1 << CW) - 1) ? exp_miss : exp_miss + 1;
        end
      end
      exp_lk = lk_valid && (!wr_valid || last_wr);
      exp_wr = wr_valid && !exp_lk;
      checkOutput("lk_grant", lk_valid && lk_ready, exp_lk);
      checkOutput("wr_grant", wr_valid && wr_ready, exp_wr);
      if (exp_lk) begin
        checkOutput("lk_ram_we", ram_we, 1'b0);
        checkOutput("lk_ram_addr", ram_addr, lk_index);
        e.idx = lk_index;
        e.hit = model_mem[lk_index][DW-1] && (model_mem[lk_index][TW-1:0] == lk_tag);
        exp_q.push_back(e);
        last_wr = 1'b0;
      end else if (exp_wr) begin
        checkOutput("wr_ram_we", ram_we, 1'b1);
        checkOutput("wr_ram_addr", ram_addr, wr_index);
        checkOutput("wr_ram_din", ram_din, wr_inval ? '0 : {1'b1, wr_tag});
        model_mem[wr_index] = wr_inval ? '0 : {1'b1, wr_tag};
        last_wr = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    reset = 1'b1;
    lk_valid = 1'b0; lk_index = '0; lk_tag = '0;
    wr_valid = 1'b0; wr_index = '0; wr_tag = '0; wr_inval = 1'b0;
    @(posedge clock);
    #1;
    lk_valid = 1'b1;
    wr_valid = 1'b1;
    @(negedge clock);
    checkOutput("rst_lk_ready", lk_ready, 1'b0);
    checkOutput("rst_wr_ready", wr_ready, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_hit", rsp_hit, 1'b0);
    checkOutput("rst_rsp_index", rsp_index, 0);
    checkOutput("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_din", ram_din, 0);
    checkOutput("rst_hit_cnt", hit_cnt, 0);
    checkOutput("rst_miss_cnt", miss_cnt, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wr_valid = 1'b0;
    lk_index = 3'd3;
`ifdef TAG_RAM_CTRL_INIT_SWEEP_EN
    for (int i = 0; i < 4; i++) begin
      a = AW'(i);
      @(negedge clock);
      checkOutput("sweep1_we", ram_we, 1'b1);
      checkOutput("sweep1_addr", ram_addr, a);
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_we", ram_we, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      @(negedge clock);
      checkOutput("sweep_we", ram_we, 1'b1);
      checkOutput("sweep_addr", ram_addr, a);
      checkOutput("sweep_din", ram_din, 0);
      checkOutput("sweep_lk_ready", lk_ready, 1'b0);
      checkOutput("sweep_wr_ready", wr_ready, 1'b0);
      @(posedge clock);
      #1;
    end
`endif
    mon_en = 1'b1;
    applyStimulus(1'b1, 3'd3, 6'h00, 1'b0, '0, '0, 1'b0);
    idleCycles(1);

    applyStimulus(1'b0, '0, '0, 1'b1, 3'd2, 6'h15, 1'b0);
    applyStimulus(1'b1, 3'd2, 6'h15, 1'b0, '0, '0, 1'b0);
    lk_valid = 1'b0;
    @(negedge clock);
    checkOutput("install_rsp_valid", rsp_valid, 1'b1);
    checkOutput("install_rsp_hit", rsp_hit, 1'b1);
    checkOutput("install_rsp_index", rsp_index, 3'd2);
    @(posedge clock);
    #1;
    idleCycles(1);
    checkOutput("install_hit_cnt", hit_cnt, 1);

    applyStimulus(1'b0, '0, '0, 1'b1, 3'd2, 6'h15, 1'b1);
    applyStimulus(1'b1, 3'd2, 6'h15, 1'b0, '0, '0, 1'b0);
    lk_valid = 1'b0;
    @(negedge clock);
    checkOutput("inval_rsp_hit", rsp_hit, 1'b0);
    @(posedge clock);
    #1;
    idleCycles(1);
    checkOutput("inval_miss_cnt", miss_cnt, 2);

    applyStimulus(1'b0, '0, '0, 1'b1, 3'd1, 6'h03, 1'b0);
    lk_valid = 1'b1; lk_index = 3'd1; lk_tag = 6'h07;
    wr_valid = 1'b1; wr_index = 3'd1; wr_tag = 6'h07; wr_inval = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("cont_lk_ready", lk_ready, (i % 2) == 0);
      checkOutput("cont_wr_ready", wr_ready, (i % 2) == 1);
      @(posedge clock);
      #1;
    end
    idleCycles(2);

    applyStimulus(1'b0, '0, '0, 1'b1, 3'd5, 6'h0A, 1'b0);
    applyStimulus(1'b1, 3'd5, 6'h0A, 1'b0, '0, '0, 1'b0);
    lk_valid = 1'b0;
    wr_valid = 1'b1; wr_index = 3'd5; wr_tag = 6'h0B; wr_inval = 1'b0;
    @(negedge clock);
    checkOutput("war_rsp_valid", rsp_valid, 1'b1);
    checkOutput("war_old_entry_hit", rsp_hit, 1'b1);
    @(posedge clock);
    #1;
    applyStimulus(1'b1, 3'd5, 6'h0B, 1'b0, '0, '0, 1'b0);
    idleCycles(2);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'd6, 6'h3F, 1'b0, '0, '0, 1'b0);
    idleCycles(3);
    checkOutput("sat_miss_cnt", miss_cnt, 3'd7);
    checkOutput("final_hit_cnt", hit_cnt, exp_hit);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
